// File: rtl/clk_div_prog.sv
`timescale 1ns/1ps
// Programmable integer clock divider: 50% duty output for even and odd N, a one-cycle
// tick per output period, and divisor changes applied only at a period boundary.
module clk_div_prog #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 3,
    parameter bit          ODD_50    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             err,
    output logic [WIDTH-1:0] div_cur,
    output logic             tick,
    output logic             q
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             run_q, run_d;
    logic             q_pos_q, q_pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             q_neg_q;

    logic             wrap;
    logic             accept;
    logic             legal;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH:0]   high_len;

    always_comb begin
        wrap       = (cnt_q == div_cur_q - ONE);
        accept     = div_valid && !pend_vld_q;
        legal      = |div_in[WIDTH-1:1];
        cnt_inc    = cnt_q + ONE;
        // ceil(N/2); one extra bit so N = 2^WIDTH-1 does not overflow
        high_len   = ({1'b0, div_cur_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        run_d      = run_q;
        q_pos_d    = q_pos_q;
        tick_d     = 1'b0;
        err_d      = err_q;

        if (!run_q) begin
            run_d   = 1'b1;
            cnt_d   = '0;
            q_pos_d = 1'b1;
            tick_d  = 1'b1;
        end else if (wrap) begin
            // New period (and its high time) starts on this same edge
            cnt_d   = '0;
            q_pos_d = 1'b1;
            tick_d  = 1'b1;
            if (pend_vld_q) begin
                div_cur_d  = pend_q;
                pend_vld_d = 1'b0;
            end
        end else begin
            cnt_d   = cnt_inc;
            q_pos_d = ({1'b0, cnt_inc} < high_len);
        end

        // Accept only while nothing is pending, so this never collides with the apply above
        if (accept) begin
            if (legal) begin
                pend_d     = div_in;
                pend_vld_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            div_cur_q  <= WIDTH'(RESET_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            run_q      <= 1'b0;
            q_pos_q    <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            run_q      <= run_d;
            q_pos_q    <= q_pos_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    // Half-cycle delayed copy; ANDed with q_pos it delays only the rising edge
    always_ff @(negedge clk) begin
        q_neg_q <= q_pos_q;
    end

    assign q         = (ODD_50 && div_cur_q[0]) ? (q_pos_q & q_neg_q) : q_pos_q;
    assign div_ready = !pend_vld_q;
    assign err       = err_q;
    assign div_cur   = div_cur_q;
    assign tick      = tick_q;
endmodule

// File: tb/tb_clk_div_prog.sv
`timescale 1ns/1ps
// Randomised and directed bench for clk_div_prog; a period-level model predicts every
// output at half-cycle resolution, for both the 50%-odd and posedge-only variants.
module tb_clk_div_prog;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       div_valid = 1'b0;
    logic [7:0] div_in = 8'd0;

    logic       ready1, err1, tick1, q1;
    logic [7:0] cur1;
    logic       ready0, err0, tick0, q0;
    logic [7:0] cur0;

    clk_div_prog #(.WIDTH(8), .RESET_DIV(3), .ODD_50(1'b1)) dut1 (
        .clk(clk), .rst(rst), .div_in(div_in), .div_valid(div_valid),
        .div_ready(ready1), .err(err1), .div_cur(cur1), .tick(tick1), .q(q1)
    );

    clk_div_prog #(.WIDTH(8), .RESET_DIV(3), .ODD_50(1'b0)) dut0 (
        .clk(clk), .rst(rst), .div_in(div_in), .div_valid(div_valid),
        .div_ready(ready0), .err(err0), .div_cur(cur0), .tick(tick0), .q(q0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a period is N cycles starting at cycle m_ps; divisor N, optional pending value
    bit m_run = 0;
    int m_cyc = 0;
    int m_ps = 0;
    int m_n = 3;
    int m_pv = 0;
    bit m_pend = 0;
    bit m_err = 0;

    always @(posedge clk) begin
        bit acc;
        acc = div_valid && !m_pend;
        if (!rst) begin
            m_run = 0; m_n = 3; m_pend = 0; m_err = 0;
        end else begin
            m_cyc++;
            if (!m_run) begin
                m_run = 1; m_ps = m_cyc;
            end else if (m_cyc - m_ps == m_n) begin
                m_ps = m_cyc;
                if (m_pend) begin m_n = m_pv; m_pend = 0; end
            end
            if (acc) begin
                if (div_in >= 2) begin m_pend = 1; m_pv = int'(div_in); end
                else m_err = 1;
            end
        end
    end

    // h counts half-cycles from the period start; odd N with 50% duty is high for h in 1..N
    function automatic bit exp_q(bit second_half, bit odd50);
        int h;
        if (!m_run) return 1'b0;
        h = 2 * (m_cyc - m_ps) + int'(second_half);
        if (odd50 && (m_n % 2 == 1)) return (h >= 1 && h <= m_n);
        return (h < 2 * ((m_n + 1) / 2));
    endfunction

    always @(posedge clk) begin
        #1;
        check("tick", tick1, (m_run && m_cyc == m_ps));
        check("tick_p", tick0, (m_run && m_cyc == m_ps));
        check("q_first_half", q1, exp_q(1'b0, 1'b1));
        check("q_first_half_p", q0, exp_q(1'b0, 1'b0));
        check("div_cur", cur1, m_n);
        check("div_cur_p", cur0, m_n);
        check("div_ready", ready1, !m_pend);
        check("div_ready_p", ready0, !m_pend);
        check("err", err1, m_err);
        check("err_p", err0, m_err);
    end

    always @(negedge clk) begin
        #1;
        check("q_second_half", q1, exp_q(1'b1, 1'b1));
        check("q_second_half_p", q0, exp_q(1'b1, 1'b0));
    end

    // Waveform measurement between DUT ticks: period in cycles, high time in half-cycles
    bit meas = 0;
    int p_cnt = 0, h1 = 0, h0 = 0;
    int last_p = 0, last_h1 = 0, last_h0 = 0;

    always @(posedge clk) begin
        #1;
        if (!rst) meas = 0;
        else if (tick1 === 1'b1) begin
            if (meas) begin last_p = p_cnt; last_h1 = h1; last_h0 = h0; end
            meas = 1; p_cnt = 0; h1 = 0; h0 = 0;
        end
        if (meas) begin
            p_cnt++;
            h1 += int'(q1 === 1'b1);
            h0 += int'(q0 === 1'b1);
        end
    end

    always @(negedge clk) begin
        #1;
        if (meas) begin
            h1 += int'(q1 === 1'b1);
            h0 += int'(q0 === 1'b1);
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(int v, int hold = 1);
        div_in = 8'(v);
        div_valid = 1'b1;
        step(hold);
        div_valid = 1'b0;
    endtask

    task automatic wait_n(int n, int budget, string name);
        int k = 0;
        while (m_n != n && k < budget) begin step(1); k++; end
        check(name, cur1, n);
    endtask

    task automatic wait_phase(int p, int budget, string name);
        int k = 0;
        while (!(m_run && (m_cyc - m_ps == p)) && k < budget) begin step(1); k++; end
        if (k >= budget) begin
            checks++; errors++;
            $display("FAIL %s: phase %0d not reached within %0d cycles", name, p, budget);
        end
    endtask

    task automatic check_shape(string name, int p, int hh1, int hh0);
        check({name, "_period"}, last_p, p);
        check({name, "_high_halves"}, last_h1, hh1);
        check({name, "_high_halves_p"}, last_h0, hh0);
    endtask

    initial begin
        // Reset and default divisor
        step(3);
        check("rst_q", q1, 0);
        check("rst_tick", tick1, 0);
        check("rst_ready", ready1, 1);
        check("rst_err", err1, 0);
        check("rst_div_cur", cur1, 3);
        rst = 1'b1;
        step(1);
        check("start_tick", tick1, 1);
        step(10);
        check_shape("n3", 3, 3, 4);

        // Even divisors
        send(4);
        step(3);
        check("n4_within3", cur1, 4);
        step(10);
        check_shape("n4", 4, 4, 4);
        send(2);
        wait_n(2, 10, "n2_apply");
        step(6);
        check_shape("n2", 2, 2, 2);

        // Mid-period switch 5 -> 8 with an ignored request while pending
        send(5);
        wait_n(5, 10, "n5_apply");
        step(11);
        wait_phase(2, 10, "n5_phase2");
        send(8);
        check("pend_ready_low", ready1, 0);
        div_in = 8'd9;
        div_valid = 1'b1;
        step(2);
        div_valid = 1'b0;
        check("switch_div_cur", cur1, 8);
        check("switch_ready", ready1, 1);
        check("ignored_err", err1, 0);
        check("n5_last_period", last_p, 5);
        step(17);
        check_shape("n8", 8, 8, 8);

        // Illegal divisors are flagged but leave state alone
        send(1);
        check("illegal1_err", err1, 1);
        check("illegal1_ready", ready1, 1);
        send(0);
        check("illegal0_err", err1, 1);
        check("illegal0_div_cur", cur1, 8);
        send(6);
        wait_n(6, 20, "n6_apply");
        check("err_sticky", err1, 1);

        // Maximum divisor with a reset mid-period
        send(255);
        wait_n(255, 20, "n255_apply");
        wait_phase(100, 300, "n255_phase100");
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("midrst_q", q1, 0);
        check("midrst_div_cur", cur1, 3);
        check("midrst_err", err1, 0);
        check("midrst_ready", ready1, 1);
        step(8);
        check_shape("restart_n3", 3, 3, 4);
        send(255);
        wait_n(255, 20, "n255_reapply");
        step(2 * 255 + 2);
        check_shape("n255", 255, 255, 256);

        // Random traffic: legal and illegal divisors, held requests, occasional resets
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rst = 1'b0;
                step(int'($urandom_range(1, 2)));
                rst = 1'b1;
            end else if (r < 3) begin
                send(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            end else begin
                send(int'($urandom_range(2, 12)), int'($urandom_range(1, 3)));
            end
            step(int'($urandom_range(0, 15)));
        end
        step(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
